// File: rtl/hazard_pkg.sv
// Shared encodings and widths for the hazard/stall scheduler.
// Forwarding support in hazard_ctrl is enabled by defining HAZARD_FORWARD_EN.
package hazard_pkg;

  localparam int T_W = 2;
  localparam int REG_W = 5;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  // counter must hold the longest (divide) busy period
  localparam int MD_CNT_W = $clog2(DIV_CYCLES_DEF + 1);

  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst,
                                   input logic             wr);
    return wr && (dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: down counter loaded when a mult/div leaves EX; md_busy is registered.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt;
  logic [MD_CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (md_start)
      cnt_nxt = md_div ? DIV_LD : MULT_LD;
    else if (cnt != '0)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      md_busy <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      md_busy <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall scheduler: data-hazard stalls, forwarding selects, HI/LO busy stalls.
// Define HAZARD_FORWARD_EN for EX/MEM/WB forwarding; otherwise any used-operand match stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic [T_W-1:0]   Tuse_rs_D,
  input  logic [T_W-1:0]   Tuse_rt_D,
  input  logic             md_use_D,
  input  logic [REG_W-1:0] regWA_E,
  input  logic [T_W-1:0]   Tnew_E,
  input  logic             RegWrite_E,
  input  logic [REG_W-1:0] regWA_M,
  input  logic [T_W-1:0]   Tnew_M,
  input  logic             RegWrite_M,
  input  logic [REG_W-1:0] regWA_W,
  input  logic             RegWrite_W,
  input  logic             md_start_E,
  input  logic             md_div_E,
  output logic             en_pc,
  output logic             en_fd,
  output logic             flush_de,
  output logic [1:0]       fwd_rs_D,
  output logic [1:0]       fwd_rt_D,
  output logic             md_busy
);

  logic hit_rs_e, hit_rs_m, hit_rt_e, hit_rt_m;
  logic stall_rs, stall_rt, md_stall, stall;
  logic [1:0] fwd_rs, fwd_rt;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start_E),
    .md_div   (md_div_E),
    .md_busy  (md_busy)
  );

  assign hit_rs_e = reg_hit(rs_D, regWA_E, RegWrite_E);
  assign hit_rs_m = reg_hit(rs_D, regWA_M, RegWrite_M);
  assign hit_rt_e = reg_hit(rt_D, regWA_E, RegWrite_E);
  assign hit_rt_m = reg_hit(rt_D, regWA_M, RegWrite_M);

`ifdef HAZARD_FORWARD_EN
  logic hit_rs_w, hit_rt_w;
  assign hit_rs_w = reg_hit(rs_D, regWA_W, RegWrite_W);
  assign hit_rt_w = reg_hit(rt_D, regWA_W, RegWrite_W);

  assign stall_rs = (hit_rs_e && (Tnew_E > Tuse_rs_D)) || (hit_rs_m && (Tnew_M > Tuse_rs_D));
  assign stall_rt = (hit_rt_e && (Tnew_E > Tuse_rt_D)) || (hit_rt_m && (Tnew_M > Tuse_rt_D));

  assign fwd_rs = (hit_rs_e && Tnew_E == '0) ? FWD_EX  :
                  (hit_rs_m && Tnew_M == '0) ? FWD_MEM :
                  hit_rs_w                   ? FWD_WB  : FWD_RF;
  assign fwd_rt = (hit_rt_e && Tnew_E == '0) ? FWD_EX  :
                  (hit_rt_m && Tnew_M == '0) ? FWD_MEM :
                  hit_rt_w                   ? FWD_WB  : FWD_RF;
`else
  // WB results reach ID through regfile write-before-read; producer timing is irrelevant here
  logic unused_wb;
  assign unused_wb = ^{regWA_W, RegWrite_W, Tnew_E, Tnew_M};

  assign stall_rs = (Tuse_rs_D != TUSE_NONE) && (hit_rs_e || hit_rs_m);
  assign stall_rt = (Tuse_rt_D != TUSE_NONE) && (hit_rt_e || hit_rt_m);
  assign fwd_rs   = FWD_RF;
  assign fwd_rt   = FWD_RF;
`endif

  // a start in EX also blocks HI/LO users: md_busy only rises next cycle
  assign md_stall = md_use_D && (md_busy || md_start_E);
  assign stall    = stall_rs || stall_rt || md_stall;

  always_comb begin
    en_pc    = !stall;
    en_fd    = !stall;
    flush_de = stall;
    fwd_rs_D = fwd_rs;
    fwd_rt_D = fwd_rt;
    if (!reset) begin
      en_pc    = 1'b1;
      en_fd    = 1'b1;
      flush_de = 1'b1;
      fwd_rs_D = FWD_RF;
      fwd_rt_D = FWD_RF;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, multi-cycle md/reset sequences, random vs model.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic       md_use;
    logic [4:0] wa_e;  logic [1:0] tn_e; logic rw_e;
    logic [4:0] wa_m;  logic [1:0] tn_m; logic rw_m;
    logic [4:0] wa_w;  logic rw_w;
    logic       md_start, md_div;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_D, rt_D, regWA_E, regWA_M, regWA_W;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic md_use_D, RegWrite_E, RegWrite_M, RegWrite_W, md_start_E, md_div_E;
  logic en_pc, en_fd, flush_de, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D;
  logic [7:0] got;

  int n_cmp = 0;
  int n_err = 0;
  int md_rem = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .md_use_D(md_use_D),
    .regWA_E(regWA_E), .Tnew_E(Tnew_E), .RegWrite_E(RegWrite_E),
    .regWA_M(regWA_M), .Tnew_M(Tnew_M), .RegWrite_M(RegWrite_M),
    .regWA_W(regWA_W), .RegWrite_W(RegWrite_W),
    .md_start_E(md_start_E), .md_div_E(md_div_E),
    .en_pc(en_pc), .en_fd(en_fd), .flush_de(flush_de),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .md_busy(md_busy)
  );

  assign got = {en_pc, en_fd, flush_de, fwd_rs_D, fwd_rt_D, md_busy};

  // reference: remaining busy cycles of the mult/div unit
  always @(posedge clk or negedge reset) begin
    if (!reset) md_rem = 0;
    else if (md_start_E) md_rem = md_div_E ? 10 : 5;
    else if (md_rem > 0) md_rem = md_rem - 1;
  end

  function automatic logic [7:0] mk(input bit pc, input bit fd, input bit fl,
                                    input logic [1:0] frs, input logic [1:0] frt, input bit busy);
    return {pc, fd, fl, frs, frt, busy};
  endfunction

  function automatic in_t idle_in();
    in_t v;
    v.rs = 0; v.rt = 0; v.tu_rs = 3; v.tu_rt = 3; v.md_use = 0;
    v.wa_e = 0; v.tn_e = 0; v.rw_e = 0;
    v.wa_m = 0; v.tn_m = 0; v.rw_m = 0;
    v.wa_w = 0; v.rw_w = 0; v.md_start = 0; v.md_div = 0;
    return v;
  endfunction

  function automatic void operand(input in_t v, input logic [4:0] s, input logic [1:0] tu,
                                  output bit st, output logic [1:0] fw);
    bit he, hm, hw;
    he = v.rw_e && v.wa_e == s && s != 0;
    hm = v.rw_m && v.wa_m == s && s != 0;
    hw = v.rw_w && v.wa_w == s && s != 0;
    fw = 0;
    if (FE) begin
      st = (he && int'(v.tn_e) > int'(tu)) || (hm && int'(v.tn_m) > int'(tu));
      if (he && v.tn_e == 0) fw = 1;
      else if (hm && v.tn_m == 0) fw = 2;
      else if (hw) fw = 3;
    end else begin
      st = (tu != 3) && (he || hm);
    end
  endfunction

  function automatic logic [7:0] model_out(input in_t v, input bit busy);
    bit s1, s2, st;
    logic [1:0] f1, f2;
    operand(v, v.rs, v.tu_rs, s1, f1);
    operand(v, v.rt, v.tu_rt, s2, f2);
    st = s1 || s2 || (v.md_use && (busy || v.md_start));
    return mk(!st, !st, st, f1, f2, busy);
  endfunction

  task automatic drive(input in_t v);
    rs_D = v.rs; rt_D = v.rt; Tuse_rs_D = v.tu_rs; Tuse_rt_D = v.tu_rt; md_use_D = v.md_use;
    regWA_E = v.wa_e; Tnew_E = v.tn_e; RegWrite_E = v.rw_e;
    regWA_M = v.wa_m; Tnew_M = v.tn_m; RegWrite_M = v.rw_m;
    regWA_W = v.wa_w; RegWrite_W = v.rw_w;
    md_start_E = v.md_start; md_div_E = v.md_div;
  endtask

  task automatic cyc(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got pc/fd/fl/frs/frt/busy=%b/%b/%b/%0d/%0d/%b required %b/%b/%b/%0d/%0d/%b",
               name, got[7], got[6], got[5], got[4:3], got[2:1], got[0],
               exp[7], exp[6], exp[5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  vec_t  tbl[10];
  string tname[10];

  initial begin
    in_t v;
    logic [7:0] nostall, stall_e;
    nostall = mk(1, 1, 0, 0, 0, 0);
    stall_e = mk(0, 0, 1, 0, 0, 0);

    v = idle_in(); v.wa_e = 5; v.tn_e = 2; v.rw_e = 1; v.rs = 5; v.tu_rs = 1;
    tbl[0] = '{v, stall_e}; tname[0] = "lw_hazard";
    v = idle_in(); v.wa_m = 7; v.tn_m = 0; v.rw_m = 1; v.rt = 7; v.tu_rt = 0;
    tbl[1] = '{v, FE ? mk(1, 1, 0, 0, 2, 0) : stall_e}; tname[1] = "mem_fwd";
    v.wa_e = 7; v.tn_e = 0; v.rw_e = 1;
    tbl[2] = '{v, FE ? mk(1, 1, 0, 0, 1, 0) : stall_e}; tname[2] = "ex_over_mem";
    v = idle_in(); v.wa_e = 0; v.tn_e = 2; v.rw_e = 1; v.rs = 0; v.tu_rs = 0;
    tbl[3] = '{v, nostall}; tname[3] = "reg0";
    v = idle_in(); v.wa_w = 9; v.rw_w = 1; v.rs = 9; v.tu_rs = 0;
    tbl[4] = '{v, FE ? mk(1, 1, 0, 3, 0, 0) : nostall}; tname[4] = "wb_fwd";
    v = idle_in(); v.wa_e = 4; v.tn_e = 2; v.rw_e = 1; v.rs = 4; v.tu_rs = 3;
    tbl[5] = '{v, nostall}; tname[5] = "tuse_none";
    v = idle_in(); v.wa_e = 6; v.tn_e = 1; v.rw_e = 1; v.rs = 6; v.tu_rs = 1;
    tbl[6] = '{v, FE ? nostall : stall_e}; tname[6] = "tnew_eq_tuse";
    v = idle_in(); v.wa_e = 8; v.tn_e = 2; v.rw_e = 0; v.rt = 8; v.tu_rt = 0;
    tbl[7] = '{v, nostall}; tname[7] = "no_regwrite";
    v = idle_in(); v.md_use = 1;
    tbl[8] = '{v, nostall}; tname[8] = "md_use_idle";
    v = idle_in(); v.wa_m = 3; v.tn_m = 1; v.rw_m = 1; v.rt = 3; v.tu_rt = 0;
    tbl[9] = '{v, stall_e}; tname[9] = "mem_tnew1";

    // reset held: a hazard present must not matter
    reset = 1'b0;
    drive(tbl[0].in);
    #2;
    check("reset_held", mk(1, 1, 1, 0, 0, 0));
    @(negedge clk); reset = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].in);
      check(tname[i], tbl[i].exp);
    end

    // mult: stall on start cycle plus 5 busy cycles
    v = idle_in(); v.md_use = 1; v.md_start = 1; v.md_div = 0;
    cyc(v); check("mult_start", mk(0, 0, 1, 0, 0, 0));
    v.md_start = 0;
    for (int k = 0; k < 5; k++) begin cyc(v); check("mult_busy", mk(0, 0, 1, 0, 0, 1)); end
    cyc(v); check("mult_done", mk(1, 1, 0, 0, 0, 0));

    // div: 10 busy cycles
    v.md_start = 1; v.md_div = 1;
    cyc(v); check("div_start", mk(0, 0, 1, 0, 0, 0));
    v.md_start = 0;
    for (int k = 0; k < 10; k++) begin cyc(v); check("div_busy", mk(0, 0, 1, 0, 0, 1)); end
    cyc(v); check("div_done", mk(1, 1, 0, 0, 0, 0));

    // reset pulse while a divide is 6 cycles from done
    v.md_start = 1;
    cyc(v);
    v.md_start = 0;
    for (int k = 0; k < 5; k++) cyc(v);
    check("div_cnt6_busy", mk(0, 0, 1, 0, 0, 1));
    reset = 1'b0;
    #1; check("reset_mid_div", mk(1, 1, 1, 0, 0, 0));
    #1; reset = 1'b1;
    cyc(v); check("mfhi_after_reset", mk(1, 1, 0, 0, 0, 0));

    // random traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
      v.tu_rs = 2'($urandom_range(0, 3)); v.tu_rt = 2'($urandom_range(0, 3));
      v.md_use = 1'($urandom_range(0, 1));
      v.wa_e = 5'($urandom_range(0, 3)); v.tn_e = 2'($urandom_range(0, 2)); v.rw_e = 1'($urandom_range(0, 1));
      v.wa_m = 5'($urandom_range(0, 3)); v.tn_m = 2'($urandom_range(0, 1)); v.rw_m = 1'($urandom_range(0, 1));
      v.wa_w = 5'($urandom_range(0, 3)); v.rw_w = 1'($urandom_range(0, 1));
      v.md_start = ($urandom_range(0, 11) == 0); v.md_div = 1'($urandom_range(0, 1));
      cyc(v);
      check("random", model_out(v, md_rem > 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
